// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: default operand width and FSM encoding.
package div_pkg;
  localparam int DIV_WIDTH = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational: shift in a dividend bit, trial-subtract.
// The compare is done one bit wider than the remainder so it can never overflow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;

  always_comb begin
    shifted  = {rem, bit_in};
    q_bit    = (shifted >= {2'b00, divisor});
    rem_next = q_bit ? (WIDTH+1)'(shifted - {2'b00, divisor}) : shifted[WIDTH:0];
  end
endmodule

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per clock; done WIDTH clocks after start (next clock on /0).
// start is ignored while busy; results hold until the next accepted division completes.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  // dvd doubles as the quotient: dividend bits shift out the top, quotient bits shift in the bottom
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (dvd[WIDTH-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            dvd <= dividend;
            dsr <= divisor;
            rem <= '0;
            cnt <= '0;
            if (divisor == '0) begin
              state       <= FIN;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= FIN;
            quotient    <= {dvd[WIDTH-2:0], q_bit};
            remainder   <= rem_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);
endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: scoreboard of expected results checked on every done pulse,
// plus latency/busy checks, start-while-busy, mid-run reset, back-to-back and an 8-bit instance.
module tb_seq_div;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  logic        start8;
  logic [7:0]  dividend8, divisor8;
  logic        busy8, done8, div_by_zero8;
  logic [7:0]  quotient8, remainder8;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;
  exp_t sb[$];

  seq_div #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  seq_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(div_by_zero8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic sb_push(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    if (push) sb_push(a, b);
  endtask

  // Latency counts negedges after the accepting edge: a normal division shows done at
  // negedge 17 (after edge k+16), a divide-by-zero at negedge 1 (after edge k).
  task automatic run_wait(input string tag, input int exp_lat, input int exp_busy, input int poke_at);
    int lat = 0;
    int busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == poke_at);
      if (i == poke_at) begin dividend = 16'd50; divisor = 16'd5; end
      if (busy) busy_n++;
      if (done) begin lat = i; break; end
    end
    if (lat == 0) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_n, exp_busy);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(16'd100, 16'd7, 1);      run_wait("d100_7", 17, 16, 0);
    issue(16'hFFFF, 16'h0001, 1);  run_wait("dffff_1", 17, 16, 0);
    issue(16'h0003, 16'h000A, 1);  run_wait("d3_10", 17, 16, 0);
    issue(16'd5, 16'd0, 1);        run_wait("d5_0", 1, 0, 0);

    // start mid-run must be ignored
    issue(16'd100, 16'd7, 1);      run_wait("ignore", 17, 16, 4);
    @(negedge clk);
    chk("hold_quotient", quotient, 14);
    chk("hold_remainder", remainder, 2);
    chk("done_single_pulse", done, 0);
    repeat (20) @(negedge clk);

    // reset mid-run, away from any clock edge
    issue(16'd1000, 16'd3, 0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrun_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_busy", busy, 0);
    chk("midrun_done", done, 0);
    chk("midrun_quotient", quotient, 0);
    chk("midrun_remainder", remainder, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'd1000, 16'd3, 1);     run_wait("d1000_3", 17, 16, 0);

    // back-to-back with start held through FIN
    begin
      int gap = 0;
      bit seen = 1'b0;
      issue(16'd9, 16'd2, 1);
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (done) begin
          dividend = 16'd9; divisor = 16'd3;
          sb_push(16'd9, 16'd3);
          seen = 1'b1;
          break;
        end
      end
      chk("b2b_first_done", seen, 1);
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (j == 1) start = 1'b0;
        if (done) begin gap = j; break; end
      end
      chk("b2b_gap", gap, 17);
    end

    // 8-bit instance
    begin
      int lat = 0;
      int busy_n = 0;
      @(negedge clk);
      start8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (i == 1) start8 = 1'b0;
        if (busy8) busy_n++;
        if (done8) begin lat = i; break; end
      end
      chk("w8_latency", lat, 9);
      chk("w8_busy_cycles", busy_n, 8);
      chk("w8_quotient", quotient8, 14);
      chk("w8_remainder", remainder8, 2);
      chk("w8_dbz", div_by_zero8, 0);
    end

    repeat (25) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; the block uses this single clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a division; sampled on clk rising edge.
REQ-005 dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
REQ-006 divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
REQ-007 busy  output  1  high while an iteration sequence is in progress.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 quotient  output  WIDTH  unsigned quotient.
REQ-010 remainder  output  WIDTH  unsigned remainder.
REQ-011 div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-012 Operation SHALL be unsigned restoring division, one quotient bit per clock, MSB first.
REQ-013 FSM states SHALL be IDLE, RUN and FIN.
REQ-014 IDLE or FIN with start=1 SHALL capture the operands, clear the partial remainder and bit counter, and move to RUN (divisor non-zero) or FIN (divisor zero).
REQ-015 IDLE or FIN with start=0 SHALL move to or stay in IDLE.
REQ-016 Each RUN cycle SHALL perform: shift {rem, dividend-MSB} left; if the result >= divisor, subtract and shift in quotient bit 1, else shift in 0.
REQ-017 RUN SHALL last exactly WIDTH cycles, counted by a clog2(WIDTH+1)-bit counter, then move to FIN.
REQ-018 Latency: with start accepted at edge k, done SHALL be high for the single cycle after edge k+WIDTH (16 clocks for WIDTH=16).
REQ-019 Divide by zero: done SHALL be high for the cycle after edge k, with quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in FIN.
REQ-021 start while in RUN SHALL be ignored; operands and progress SHALL be unaffected.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from FIN until the next accepted start completes.
REQ-023 Back-to-back operation: start high during FIN SHALL be accepted, so done-to-done spacing is WIDTH+1 cycles.
REQ-024 The internal remainder register SHALL be WIDTH+1 bits so the compare never overflows.

Reset
REQ-025 rst_n low SHALL force IDLE immediately, regardless of clk, including mid-RUN.
REQ-026 Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0.
REQ-027 A division interrupted by reset SHALL produce no done pulse.
REQ-028 The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-029 Package div_pkg SHALL hold the default WIDTH constant and the FSM state encoding (IDLE, RUN, FIN).
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring step.
REQ-031 div_step inputs: partial remainder, incoming dividend bit, divisor.
REQ-032 div_step outputs: next remainder, quotient bit.
REQ-033 Only datapath registers, counter and FSM SHALL reside in seq_div.

Verification
REQ-034 Divide 100 by 7, then the same division with WIDTH=8: expect quotient=14, remainder=2, div_by_zero=0, done exactly 16 clocks (WIDTH=16) or 8 clocks (WIDTH=8) after the start edge, busy high for the preceding cycles.
REQ-035 Divide 0xFFFF by 0x0001, then 0x0003 by 0x000A: expect quotient=0xFFFF, remainder=0 for the first, quotient=0, remainder=3 for the second.
REQ-036 Divide 5 by 0: expect done one clock after start, quotient=0xFFFF, remainder=5, div_by_zero=1, busy never high.
REQ-037 During 100/7, pulse start with 50/5 at RUN cycle 4: expect result still 14 r 2 and no second done.
REQ-038 Assert rst_n low at RUN cycle 8 of 1000/3: expect immediate busy=0, outputs=0, no done; a following 1000/3 yields 333 r 1.
REQ-039 Hold start high through FIN on consecutive 9/2 and 9/3: expect 4 r 1, then 3 r 0, with done pulses 17 cycles apart.
